cv32e40p_data_mem: RTL and testbench
====================================

# cv32e40p_data_mem

Single-port, byte-enabled data memory with a small MMIO window. It is the responder at the far end of the core's data interface: it accepts the load/store unit's address, write enable, byte enables and write data, and returns a full read word one cycle later. The LSU performs all byte/halfword extraction, sign extension and misaligned splitting; this block always operates on whole aligned words. The MMIO window provides a 64-bit machine timer with compare interrupt, a test-exit register, and a console byte FIFO with a valid/ready drain port.

## Interface
- `DEPTH_WORDS`, default 4096: RAM depth in 32-bit words; must be a power of two.
- `MMIO_BASE`, default 32'h1000_0000: base address of the MMIO window, 256-byte aligned.
- `TX_DEPTH`, default 4: console FIFO depth; must be a power of two, at least 2.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_req_i` in 1: access request, gated by the core with the LSU request.
- `data_addr_i` in 32: byte address; bits [1:0] ignored.
- `data_we_i` in 1: 1 = store, 0 = load.
- `data_be_i` in 4: byte enables for stores; ignored for loads.
- `data_wdata_i` in 32: store data, already lane-aligned by the LSU.
- `data_rdata_o` out 32: registered read word.
- `access_err_o` out 1: one-cycle pulse for an unmapped access or a dropped console push.
- `timer_irq_o` out 1: registered `mtime >= mtimecmp`.
- `halt_o` out 1: sticky test-exit flag.
- `exit_code_o` out 31: exit code latched with `halt_o`.
- `tx_valid_o` out 1: console FIFO is non-empty.
- `tx_data_o` out 8: FIFO head byte.
- `tx_ready_i` in 1: sink accepts the head byte.

## Operation
- Word index is `data_addr_i[31:2]`.
- RAM hit: `data_addr_i < DEPTH_WORDS*4`.
- MMIO hit: `data_addr_i[31:8] == MMIO_BASE[31:8]`, with one of the offsets below.
- Any other address is unmapped.
- RAM store: on the clock edge, each byte lane whose `data_be_i` bit is set is written; the other lanes are untouched. `be == 0` is a legal no-op.
- RAM load: the addressed word is captured into `data_rdata_o` on the clock edge.
- MMIO offsets (byte lanes honoured on every register):
  - 0x00 `MTIME_LO`, 0x04 `MTIME_HI`: 64-bit counter, +1 every cycle.
  - 0x08 `MTIMECMP_LO`, 0x0C `MTIMECMP_HI`: reset value all ones.
  - 0x10 `TOHOST`: a write with `wdata[0]=1` sets `halt_o` and latches `exit_code_o = wdata[31:1]`. Reads return {exit_code, halt}.
  - 0x14 `TX_DATA`: a write with `be[0]=1` pushes `wdata[7:0]`. Reads return 0.
  - 0x18 `TX_STAT`: read-only; bit0 = full, bit1 = empty, bits [7:4] = count, all other bits 0.
- Unmapped load: `data_rdata_o = 32'hDEAD_BEEF` and `access_err_o` pulses. Unmapped store: ignored and `access_err_o` pulses.
- Writes to read-only MMIO offsets are ignored and raise no error.
- No request, or a store: `data_rdata_o` holds its previous value.
- Timer write cycle: the counter does not increment. Written bytes take `wdata`; unwritten bytes hold.
- FIFO push while full: the byte is dropped and `access_err_o` pulses. Fullness uses the count before any pop in the same cycle.
- FIFO pop: occurs when `tx_valid_o && tx_ready_i`. A push and pop in the same cycle on a non-full FIFO leaves count unchanged.
- `halt_o` clears only on reset. A second `TOHOST` write does not change `exit_code_o`.

## Timing
- Read latency is exactly 1 cycle: request in cycle N, data valid after the edge ending cycle N. This matches the LSU, which samples rdata in WB one cycle after the request.
- Store effects are visible to a load issued in the next cycle.
- `access_err_o` and the `halt_o` rise both appear 1 cycle after the request.
- `timer_irq_o` is registered from the current counter value: it asserts 1 cycle after `mtime` reaches `mtimecmp`. It deasserts 1 cycle after a `MTIMECMP` write raises the compare value above `mtime`.
- FIFO: a push into an empty FIFO raises `tx_valid_o` the next cycle. `tx_data_o` is stable while `tx_valid_o && !tx_ready_i`.
- Reset values:
  - `data_rdata_o` 0, `access_err_o` 0, `timer_irq_o` 0.
  - `halt_o` 0, `exit_code_o` 0, `tx_valid_o` 0, `tx_data_o` 0.
  - `mtime` 0, FIFO empty.
  - RAM contents are not reset.
- Reset asserted mid-operation clears all registers immediately, including any queued console bytes.

## Structure
- Package `cv32e40p_data_mem_pkg` holds:
  - MMIO offset localparams (`MTIME_LO` … `TX_STAT`).
  - `BAD_RDATA = 32'hDEAD_BEEF`.
  - an `mmio_sel_e` enum for decoded targets.
- Sub-module `cv32e40p_data_mem_tx_fifo`:
  - parameters: `TX_DEPTH` and width 8.
  - ports: push/data in, valid/ready out, full/empty/count outputs.
  - implementation: wrap-around read and write pointers one bit wider than the index.
- RAM is an inferred array with per-lane write enables.

## Test plan
- Store `0xAABBCCDD` to 0x100 with be=1111, then store be=0010 with wdata `0x0000_1100` → a load from 0x100 returns `0xAABB11DD` one cycle later.
- Load from address 0x103 → returns the word at 0x100 (low bits ignored); the rdata output holds its value through an idle cycle.
- Load from 0x2000_0000 → rdata `0xDEADBEEF` and a single `access_err_o` pulse; a store to the same address leaves RAM unchanged.
- Write `MTIMECMP_HI=0` and `MTIMECMP_LO=20`, with `MTIME=0` written on that same cycle → `timer_irq_o` rises 21 cycles after that write.
- With `tx_ready_i=0`, push 5 bytes → `TX_STAT` reads full/count=4; the 5th push pulses `access_err_o`. Then with `tx_ready_i=1`, bytes 1–4 drain in order over 4 cycles.
- Write `TOHOST = 0x0000_0007` → `halt_o=1` and `exit_code_o=3` the next cycle; a following `TOHOST` write leaves `exit_code_o` unchanged; reset clears both.

Source files
------------

// File: rtl/cv32e40p_data_mem_pkg.sv
// Shared definitions for the cv32e40p data memory: MMIO offsets, decode targets
// and the byte-lane merge helper used by every writable register.
package cv32e40p_data_mem_pkg;

    localparam logic [7:0] MTIME_LO    = 8'h00;
    localparam logic [7:0] MTIME_HI    = 8'h04;
    localparam logic [7:0] MTIMECMP_LO = 8'h08;
    localparam logic [7:0] MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] TOHOST      = 8'h10;
    localparam logic [7:0] TX_DATA     = 8'h14;
    localparam logic [7:0] TX_STAT     = 8'h18;

    localparam logic [31:0] BAD_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [3:0] {
        SEL_RAM         = 4'd0,
        SEL_MTIME_LO    = 4'd1,
        SEL_MTIME_HI    = 4'd2,
        SEL_MTIMECMP_LO = 4'd3,
        SEL_MTIMECMP_HI = 4'd4,
        SEL_TOHOST      = 4'd5,
        SEL_TX_DATA     = 4'd6,
        SEL_TX_STAT     = 4'd7,
        SEL_UNMAPPED    = 4'd8
    } mmio_sel_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/cv32e40p_data_mem_tx_fifo.sv
// Console byte FIFO with a valid/ready drain port; pushes while full are dropped
// here and flagged by the parent, which sees the same full signal.
module cv32e40p_data_mem_tx_fifo
    import cv32e40p_data_mem_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int WIDTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(TX_DEPTH):0]   o_count
);

    localparam int PW = $clog2(TX_DEPTH);

    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [TX_DEPTH];
    logic             w_push_ok;
    logic             w_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign o_valid   = !o_empty;
    assign o_data    = r_mem[r_rd_ptr[PW-1:0]];
    assign w_push_ok = i_push && !o_full;
    assign w_pop     = o_valid && i_ready;

    // Storage is cleared on reset so the head byte reads zero when empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {(PW+1){1'b0}};
            r_rd_ptr <= {(PW+1){1'b0}};
            for (int i = 0; i < TX_DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[PW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + {{PW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{PW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/cv32e40p_data_mem.sv
// Data-side responder for the core: byte-enabled word RAM plus an MMIO window
// holding the machine timer, the test-exit register and the console FIFO.
module cv32e40p_data_mem
    import cv32e40p_data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
    parameter int unsigned TX_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        access_err_o,
    output logic        timer_irq_o,
    output logic        halt_o,
    output logic [30:0] exit_code_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam int unsigned CW        = $clog2(TX_DEPTH) + 1;
    localparam logic [33:0] RAM_BYTES = 34'(DEPTH_WORDS) << 2;

    logic [31:0]   r_ram [DEPTH_WORDS];
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          r_irq;
    logic          r_halt;
    logic [30:0]   r_exit_code;
    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;

    mmio_sel_e     w_sel;
    logic [31:0]   w_rd_word;
    logic [AW-1:0] w_ram_idx;
    logic          w_wr;
    logic          w_push;
    logic          w_err;
    logic [31:0]   w_tohost_new;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic [CW-1:0] w_tx_count;
    logic          w_unused_addr_bits;

    assign w_ram_idx          = data_addr_i[AW+1:2];
    assign w_unused_addr_bits = ^data_addr_i[1:0];
    assign w_wr               = data_req_i && data_we_i;
    assign w_push             = w_wr && (w_sel == SEL_TX_DATA) && data_be_i[0];
    assign w_err              = data_req_i && ((w_sel == SEL_UNMAPPED) || (w_push && w_tx_full));
    assign w_tohost_new       = be_merge({r_exit_code, r_halt}, data_wdata_i, data_be_i);

    // Address decode: RAM first, then the known MMIO offsets, everything else unmapped.
    always_comb begin
        w_sel = SEL_UNMAPPED;
        if ({2'b00, data_addr_i} < RAM_BYTES) begin
            w_sel = SEL_RAM;
        end else if (data_addr_i[31:8] == MMIO_BASE[31:8]) begin
            case ({data_addr_i[7:2], 2'b00})
                MTIME_LO:    w_sel = SEL_MTIME_LO;
                MTIME_HI:    w_sel = SEL_MTIME_HI;
                MTIMECMP_LO: w_sel = SEL_MTIMECMP_LO;
                MTIMECMP_HI: w_sel = SEL_MTIMECMP_HI;
                TOHOST:      w_sel = SEL_TOHOST;
                TX_DATA:     w_sel = SEL_TX_DATA;
                TX_STAT:     w_sel = SEL_TX_STAT;
                default:     w_sel = SEL_UNMAPPED;
            endcase
        end else begin
            w_sel = SEL_UNMAPPED;
        end
    end

    // Read word selection; timer reads see the value before this cycle's update.
    always_comb begin
        w_rd_word = BAD_RDATA;
        case (w_sel)
            SEL_RAM:         w_rd_word = r_ram[w_ram_idx];
            SEL_MTIME_LO:    w_rd_word = r_mtime[31:0];
            SEL_MTIME_HI:    w_rd_word = r_mtime[63:32];
            SEL_MTIMECMP_LO: w_rd_word = r_mtimecmp[31:0];
            SEL_MTIMECMP_HI: w_rd_word = r_mtimecmp[63:32];
            SEL_TOHOST:      w_rd_word = {r_exit_code, r_halt};
            SEL_TX_DATA:     w_rd_word = 32'h0000_0000;
            SEL_TX_STAT:     w_rd_word = {24'h00_0000, 4'(w_tx_count), 2'b00, w_tx_empty, w_tx_full};
            default:         w_rd_word = BAD_RDATA;
        endcase
    end

    // RAM contents are not reset.
    always_ff @(posedge clk) begin
        if (w_wr && (w_sel == SEL_RAM)) begin
            for (int i = 0; i < 4; i++) begin
                if (data_be_i[i]) begin
                    r_ram[w_ram_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Registered responses, timer and test-exit state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata     <= 32'h0000_0000;
            r_err       <= 1'b0;
            r_irq       <= 1'b0;
            r_halt      <= 1'b0;
            r_exit_code <= 31'h0000_0000;
            r_mtime     <= 64'h0;
            r_mtimecmp  <= {64{1'b1}};
        end else begin
            r_err <= w_err;
            r_irq <= (r_mtime >= r_mtimecmp);
            if (data_req_i && !data_we_i) begin
                r_rdata <= w_rd_word;
            end
            // A timer write freezes the whole counter for that cycle.
            if (w_wr && (w_sel == SEL_MTIME_LO)) begin
                r_mtime[31:0] <= be_merge(r_mtime[31:0], data_wdata_i, data_be_i);
            end else if (w_wr && (w_sel == SEL_MTIME_HI)) begin
                r_mtime[63:32] <= be_merge(r_mtime[63:32], data_wdata_i, data_be_i);
            end else begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (w_wr && (w_sel == SEL_MTIMECMP_LO)) begin
                r_mtimecmp[31:0] <= be_merge(r_mtimecmp[31:0], data_wdata_i, data_be_i);
            end else if (w_wr && (w_sel == SEL_MTIMECMP_HI)) begin
                r_mtimecmp[63:32] <= be_merge(r_mtimecmp[63:32], data_wdata_i, data_be_i);
            end
            if (w_wr && (w_sel == SEL_TOHOST) && !r_halt && w_tohost_new[0]) begin
                r_halt      <= 1'b1;
                r_exit_code <= w_tohost_new[31:1];
            end
        end
    end

    cv32e40p_data_mem_tx_fifo #(
        .TX_DEPTH (TX_DEPTH),
        .WIDTH    (8)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (data_wdata_i[7:0]),
        .o_valid (tx_valid_o),
        .i_ready (tx_ready_i),
        .o_data  (tx_data_o),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    assign data_rdata_o = r_rdata;
    assign access_err_o = r_err;
    assign timer_irq_o  = r_irq;
    assign halt_o       = r_halt;
    assign exit_code_o  = r_exit_code;

endmodule

// File: tb/tb_cv32e40p_data_mem.sv
// Directed and random checks of cv32e40p_data_mem against a behavioural model.
module tb_cv32e40p_data_mem;

    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b1;
    logic        data_req_i   = 1'b0;
    logic [31:0] data_addr_i  = 32'h0;
    logic        data_we_i    = 1'b0;
    logic [3:0]  data_be_i    = 4'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        tx_ready_i   = 1'b0;
    logic [31:0] data_rdata_o;
    logic        access_err_o;
    logic        timer_irq_o;
    logic        halt_o;
    logic [30:0] exit_code_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cv32e40p_data_mem dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_req_i   (data_req_i),
        .data_addr_i  (data_addr_i),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .access_err_o (access_err_o),
        .timer_irq_o  (timer_irq_o),
        .halt_o       (halt_o),
        .exit_code_o  (exit_code_o),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .tx_ready_i   (tx_ready_i)
    );

    // Reference model state
    logic [31:0] m_ram [int];
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_irq;
    logic        m_halt;
    logic        m_err;
    logic [30:0] m_exit;
    logic [31:0] m_rdata;
    bit          m_rd_known;
    logic [7:0]  m_fifo [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_mtime    = 64'h0;
        m_cmp      = {64{1'b1}};
        m_irq      = 1'b0;
        m_halt     = 1'b0;
        m_err      = 1'b0;
        m_exit     = 31'h0;
        m_rdata    = 32'h0;
        m_rd_known = 1'b1;
        m_fifo.delete();
    endtask

    task automatic model_edge(input logic req, input logic [31:0] addr, input logic we,
                              input logic [3:0] be, input logic [31:0] wd, input logic rdy);
        logic [31:0] a, rd, tmp;
        int          sz, idx;
        bit          err, push, known, tick, nxt_irq;
        a       = {addr[31:2], 2'b00};
        idx     = int'(a >> 2);
        sz      = m_fifo.size();
        nxt_irq = (m_mtime >= m_cmp);
        err = 1'b0; push = 1'b0; known = 1'b1; tick = 1'b1; rd = 32'hDEAD_BEEF;
        if (req) begin
            if (a < 32'h0000_4000) begin
                if (we) begin
                    tmp = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
                    m_ram[idx] = lanes(tmp, wd, be);
                end else begin
                    known = m_ram.exists(idx);
                    rd    = known ? m_ram[idx] : 32'h0;
                end
            end else if ((a[31:8] == MB[31:8]) && (a[7:0] <= 8'h18)) begin
                case (a[7:0])
                    8'h00: begin rd = m_mtime[31:0];  if (we) begin m_mtime[31:0]  = lanes(m_mtime[31:0], wd, be);  tick = 1'b0; end end
                    8'h04: begin rd = m_mtime[63:32]; if (we) begin m_mtime[63:32] = lanes(m_mtime[63:32], wd, be); tick = 1'b0; end end
                    8'h08: begin rd = m_cmp[31:0];    if (we) m_cmp[31:0]  = lanes(m_cmp[31:0], wd, be);  end
                    8'h0C: begin rd = m_cmp[63:32];   if (we) m_cmp[63:32] = lanes(m_cmp[63:32], wd, be); end
                    8'h10: begin
                        rd = {m_exit, m_halt};
                        if (we && be[0] && wd[0] && !m_halt) begin
                            tmp    = lanes(32'h0, wd, be);
                            m_halt = 1'b1;
                            m_exit = tmp[31:1];
                        end
                    end
                    8'h14: begin
                        rd = 32'h0;
                        if (we && be[0]) begin
                            if (sz == 4) err = 1'b1;
                            else push = 1'b1;
                        end
                    end
                    default: rd = {24'h0, sz[3:0], 2'b00, sz == 0, sz == 4};
                endcase
            end else begin
                err = 1'b1;
            end
        end
        if (tick) m_mtime = m_mtime + 64'd1;
        if ((sz > 0) && rdy) void'(m_fifo.pop_front());
        if (push) m_fifo.push_back(wd[7:0]);
        if (req && !we) begin
            m_rdata    = rd;
            m_rd_known = known;
        end
        m_err = err;
        m_irq = nxt_irq;
    endtask

    task automatic check_all();
        if (m_rd_known) check("rdata", data_rdata_o, m_rdata);
        check("access_err", access_err_o, m_err);
        check("timer_irq", timer_irq_o, m_irq);
        check("halt", halt_o, m_halt);
        check("exit_code", exit_code_o, m_exit);
        check("tx_valid", tx_valid_o, m_fifo.size() != 0);
        if (m_fifo.size() != 0) check("tx_data", tx_data_o, m_fifo[0]);
    endtask

    task automatic cycle(input logic req, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
        data_req_i   = req;
        data_addr_i  = addr;
        data_we_i    = we;
        data_be_i    = be;
        data_wdata_i = wd;
        @(posedge clk);
        model_edge(req, addr, we, be, wd, tx_ready_i);
        #1;
        check_all();
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        data_req_i = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned kind;
        logic [31:0] addr;
        #2;
        do_reset();

        // RAM byte lanes, ignored low address bits, rdata hold
        cycle(1'b1, 32'h0000_0000, 1'b1, 4'hF, 32'h0BAD_F00D);
        cycle(1'b1, 32'h0000_0100, 1'b1, 4'hF, 32'hAABB_CCDD);
        cycle(1'b1, 32'h0000_0100, 1'b1, 4'b0010, 32'h0000_1100);
        cycle(1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0);
        check("ram_lane_merge", data_rdata_o, 32'hAABB_11DD);
        cycle(1'b1, 32'h0000_0103, 1'b0, 4'h0, 32'h0);
        check("addr_low_bits", data_rdata_o, 32'hAABB_11DD);
        idle();
        check("rdata_hold", data_rdata_o, 32'hAABB_11DD);

        // Unmapped accesses
        cycle(1'b1, 32'h2000_0000, 1'b0, 4'h0, 32'h0);
        check("unmapped_rdata", data_rdata_o, 32'hDEAD_BEEF);
        check("unmapped_err", access_err_o, 1'b1);
        idle();
        check("err_single_pulse", access_err_o, 1'b0);
        cycle(1'b1, 32'h2000_0000, 1'b1, 4'hF, 32'h1234_5678);
        check("unmapped_store_err", access_err_o, 1'b1);
        cycle(1'b1, 32'h0000_0000, 1'b0, 4'h0, 32'h0);
        check("unmapped_store_no_alias", data_rdata_o, 32'h0BAD_F00D);

        // Timer compare
        cycle(1'b1, MB + 32'h08, 1'b1, 4'hF, 32'd20);
        cycle(1'b1, MB + 32'h0C, 1'b1, 4'hF, 32'd0);
        cycle(1'b1, MB + 32'h04, 1'b1, 4'hF, 32'd0);
        cycle(1'b1, MB + 32'h00, 1'b1, 4'hF, 32'd0);
        for (int k = 1; k <= 21; k++) begin
            idle();
            if (k == 20) check("irq_before_match", timer_irq_o, 1'b0);
            if (k == 21) check("irq_rise", timer_irq_o, 1'b1);
        end
        cycle(1'b1, MB + 32'h0C, 1'b1, 4'hF, 32'hFFFF_FFFF);
        idle();
        check("irq_fall_after_cmp_write", timer_irq_o, 1'b0);

        // Console FIFO fill, overflow and drain
        tx_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, MB + 32'h14, 1'b1, 4'h1, 32'((k + 1) * 17));
            if (k == 4) check("fifo_overflow_err", access_err_o, 1'b1);
        end
        cycle(1'b1, MB + 32'h18, 1'b0, 4'h0, 32'h0);
        check("tx_stat_full", data_rdata_o, 32'h0000_0041);
        tx_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_order", tx_data_o, 8'((k + 1) * 17));
            idle();
        end
        check("drained_empty", tx_valid_o, 1'b0);

        // Test exit register
        cycle(1'b1, MB + 32'h10, 1'b1, 4'hF, 32'h0000_0007);
        check("halt_set", halt_o, 1'b1);
        check("exit_code", exit_code_o, 31'd3);
        cycle(1'b1, MB + 32'h10, 1'b1, 4'hF, 32'h0000_0011);
        check("exit_code_sticky", exit_code_o, 31'd3);
        cycle(1'b1, MB + 32'h10, 1'b0, 4'h0, 32'h0);
        check("tohost_read", data_rdata_o, 32'h0000_0007);

        // Reset in the middle of activity with queued console bytes
        tx_ready_i = 1'b0;
        cycle(1'b1, MB + 32'h14, 1'b1, 4'h1, 32'h0000_00A5);
        cycle(1'b1, MB + 32'h14, 1'b1, 4'h1, 32'h0000_005A);
        do_reset();
        check("reset_halt", halt_o, 1'b0);
        check("reset_exit", exit_code_o, 31'd0);
        check("reset_fifo", tx_valid_o, 1'b0);

        // Random traffic against the model
        for (int w = 0; w < 16; w++) cycle(1'b1, 32'(w * 4), 1'b1, 4'hF, $urandom);
        for (int n = 0; n < 800; n++) begin
            tx_ready_i = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                cycle(1'b1, addr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            end else if (kind <= 7) begin
                addr = MB + 32'($urandom_range(0, 6) * 4 + $urandom_range(0, 3));
                cycle(1'b1, addr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            end else if (kind == 8) begin
                if ($urandom_range(0, 1) == 0) addr = 32'h2000_0000 + 32'($urandom_range(0, 4095));
                else addr = MB + 32'h1C + 32'($urandom_range(0, 227));
                cycle(1'b1, addr, 1'($urandom_range(0, 1)), 4'hF, $urandom);
            end else begin
                idle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
